// File: rtl/lane_encoder.sv
// Multi-lane IEEE 802.3 clause 36 8b/10b encoder with a one-deep registered
// output stage, optional K28.5 idle insertion and invalid-K error accounting.
module lane_encoder #(
  parameter int LANES       = 4,
  parameter int IDLE_INSERT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES-1:0]    s_ctrl,
  input  logic [LANES*8-1:0]  s_data,
  input  logic [LANES-1:0]    lane_en,
  input  logic                disp_clr,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*10-1:0] m_data,
  output logic                m_idle,
  output logic [LANES-1:0]    m_disp,
  output logic                k_err,
  output logic [CNT_W-1:0]    k_err_cnt
);
  localparam int         SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [7:0] K28_5 = 8'hBC;

  logic [LANES-1:0]    rd;
  logic                free;
  logic                load_data;
  logic                load_idle;
  logic [LANES*10-1:0] enc_data;
  logic [LANES-1:0]    enc_rd;
  logic [LANES-1:0]    bad_k;
  logic [4:0]          bad_n;
  logic [SUM_W-1:0]    cnt_sum;
  logic [7:0]          byte_v;
  logic                k_v;
  logic                rd_in;
  logic [10:0]         sym_v;

  // 5b/6b table: {unbalanced, abcdei at RD-}, a in the MSB
  function automatic logic [6:0] tbl6(input logic [4:0] x);
    case (x)
      5'd0:    tbl6 = {1'b1, 6'b100111};
      5'd1:    tbl6 = {1'b1, 6'b011101};
      5'd2:    tbl6 = {1'b1, 6'b101101};
      5'd3:    tbl6 = {1'b0, 6'b110001};
      5'd4:    tbl6 = {1'b1, 6'b110101};
      5'd5:    tbl6 = {1'b0, 6'b101001};
      5'd6:    tbl6 = {1'b0, 6'b011001};
      5'd7:    tbl6 = {1'b0, 6'b111000};
      5'd8:    tbl6 = {1'b1, 6'b111001};
      5'd9:    tbl6 = {1'b0, 6'b100101};
      5'd10:   tbl6 = {1'b0, 6'b010101};
      5'd11:   tbl6 = {1'b0, 6'b110100};
      5'd12:   tbl6 = {1'b0, 6'b001101};
      5'd13:   tbl6 = {1'b0, 6'b101100};
      5'd14:   tbl6 = {1'b0, 6'b011100};
      5'd15:   tbl6 = {1'b1, 6'b010111};
      5'd16:   tbl6 = {1'b1, 6'b011011};
      5'd17:   tbl6 = {1'b0, 6'b100011};
      5'd18:   tbl6 = {1'b0, 6'b010011};
      5'd19:   tbl6 = {1'b0, 6'b110010};
      5'd20:   tbl6 = {1'b0, 6'b001011};
      5'd21:   tbl6 = {1'b0, 6'b101010};
      5'd22:   tbl6 = {1'b0, 6'b011010};
      5'd23:   tbl6 = {1'b1, 6'b111010};
      5'd24:   tbl6 = {1'b1, 6'b110011};
      5'd25:   tbl6 = {1'b0, 6'b100110};
      5'd26:   tbl6 = {1'b0, 6'b010110};
      5'd27:   tbl6 = {1'b1, 6'b110110};
      5'd28:   tbl6 = {1'b0, 6'b001110};
      5'd29:   tbl6 = {1'b1, 6'b101110};
      5'd30:   tbl6 = {1'b1, 6'b011110};
      default: tbl6 = {1'b1, 6'b101011};
    endcase
  endfunction

  function automatic logic valid_k(input logic [7:0] b);
    valid_k = (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
              (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Returns {rd_after, symbol}; symbol bit0 = a. k must already be a legal K code.
  function automatic logic [10:0] encode(input logic [7:0] b, input logic k,
                                         input logic rd_i);
    logic [4:0] x;
    logic [2:0] y;
    logic [6:0] t6;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] cat;
    logic [9:0] sym;
    logic       rd4;
    logic       unb4;
    logic       k28;
    logic       alt7;
    x    = b[4:0];
    y    = b[7:5];
    k28  = k && (x == 5'd28);
    t6   = k28 ? {1'b1, 6'b001111} : tbl6(x);
    s6   = (rd_i && (t6[6] || (x == 5'd7))) ? ~t6[5:0] : t6[5:0];
    rd4  = rd_i ^ t6[6];
    alt7 = k || (!rd4 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd4 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    case (y)
      3'd0:    begin s4 = 4'b1011; unb4 = 1'b1; end
      3'd1:    begin s4 = 4'b1001; unb4 = 1'b0; end
      3'd2:    begin s4 = 4'b0101; unb4 = 1'b0; end
      3'd3:    begin s4 = 4'b1100; unb4 = 1'b0; end
      3'd4:    begin s4 = 4'b1101; unb4 = 1'b1; end
      3'd5:    begin s4 = 4'b1010; unb4 = 1'b0; end
      3'd6:    begin s4 = 4'b0110; unb4 = 1'b0; end
      default: begin s4 = alt7 ? 4'b0111 : 4'b1110; unb4 = 1'b1; end
    endcase
    // K28 inverts the neutral 3b/4b codes when entering 3b/4b at RD-
    if (rd4 && (unb4 || (y == 3'd3))) begin
      s4 = ~s4;
    end else if (k28 && !rd4 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
      s4 = ~s4;
    end else begin
      s4 = s4;
    end
    cat = {s6, s4};
    for (int j = 0; j < 10; j++) begin
      sym[j] = cat[9-j];
    end
    encode = {rd4 ^ unb4, sym};
  endfunction

  // Handshake decode and per-lane symbol encoding for the next load
  always_comb begin
    free      = !m_valid || m_ready;
    load_data = s_valid && free;
    load_idle = (IDLE_INSERT != 0) && free && !s_valid;
    s_ready   = free;
    enc_data  = '0;
    enc_rd    = '0;
    bad_k     = '0;
    bad_n     = 5'd0;
    byte_v    = 8'h00;
    k_v       = 1'b0;
    rd_in     = 1'b0;
    sym_v     = 11'd0;
    for (int i = 0; i < LANES; i++) begin
      rd_in    = disp_clr ? 1'b0 : rd[i];
      byte_v   = load_data ? s_data[8*i +: 8] : K28_5;
      k_v      = load_data ? s_ctrl[i] : 1'b1;
      bad_k[i] = load_data && lane_en[i] && s_ctrl[i] && !valid_k(byte_v);
      sym_v    = encode(byte_v, k_v && valid_k(byte_v), rd_in);
      if (lane_en[i]) begin
        enc_data[10*i +: 10] = sym_v[9:0];
        enc_rd[i]            = sym_v[10];
      end else begin
        enc_data[10*i +: 10] = 10'h000;
        enc_rd[i]            = rd_in;
      end
      bad_n = bad_n + {4'd0, bad_k[i]};
    end
    cnt_sum = SUM_W'(k_err_cnt) + SUM_W'(bad_n);
  end

  // Output stage, running disparity and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_idle    <= 1'b0;
      m_data    <= '0;
      m_disp    <= '0;
      rd        <= '0;
      k_err     <= 1'b0;
      k_err_cnt <= '0;
    end else begin
      k_err <= load_data && (bad_n != 5'd0);
      if (load_data && (bad_n != 5'd0)) begin
        if (cnt_sum[SUM_W-1:CNT_W] != '0) begin
          k_err_cnt <= '1;
        end else begin
          k_err_cnt <= cnt_sum[CNT_W-1:0];
        end
      end else begin
        k_err_cnt <= k_err_cnt;
      end
      if (load_data || load_idle) begin
        m_valid <= 1'b1;
        m_idle  <= !load_data;
        m_data  <= enc_data;
        m_disp  <= enc_rd;
        rd      <= enc_rd;
      end else begin
        rd <= disp_clr ? '0 : rd;
        if (free) begin
          m_valid <= 1'b0;
        end else begin
          m_valid <= m_valid;
        end
      end
    end
  end
endmodule

// File: tb/tb_lane_encoder.sv
// Scoreboard bench for lane_encoder: a reference 8b/10b model predicts every
// loaded beat, which is checked when the beat is consumed downstream.
module tb_lane_encoder;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam bit IDLE_INSERT = 1'b1;

  logic                clk;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [LANES-1:0]    s_ctrl;
  logic [LANES*8-1:0]  s_data;
  logic [LANES-1:0]    lane_en;
  logic                disp_clr;
  logic                m_valid;
  logic                m_ready;
  logic [LANES*10-1:0] m_data;
  logic                m_idle;
  logic [LANES-1:0]    m_disp;
  logic                k_err;
  logic [CNT_W-1:0]    k_err_cnt;

  lane_encoder #(.LANES(LANES), .IDLE_INSERT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ctrl(s_ctrl),
    .s_data(s_data), .lane_en(lane_en), .disp_clr(disp_clr), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_idle(m_idle), .m_disp(m_disp),
    .k_err(k_err), .k_err_cnt(k_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*10-1:0] data;
    logic                idle;
    logic [LANES-1:0]    disp;
  } exp_t;

  exp_t             sb[$];
  int               nvec = 0;
  int               nmis = 0;
  logic             mdl_valid;
  logic [LANES-1:0] mdl_rd;
  logic [CNT_W-1:0] mdl_cnt;
  logic             mdl_kerr;

  // abcdei (a = MSB) at RD-, and fghj at RD- for D.x.y / K28.y entered at RD-
  localparam logic [5:0] D6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                    4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] K4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                    4'b0010, 4'b1010, 4'b0110, 4'b1000};

  function automatic logic is_k(input logic [7:0] b);
    is_k = (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  function automatic logic [10:0] model_enc(input logic [7:0] b, input logic vk, input logic rd_i);
    logic [9:0] c;
    logic [9:0] o;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       r4;
    int         ones;
    if (vk) begin
      c = (b[4:0] == 5'd28) ? {6'b001111, K4[b[7:5]]} : {D6[b[4:0]], 4'b1000};
      if (rd_i) c = ~c;
    end else begin
      c6 = D6[b[4:0]];
      if (rd_i && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
      r4 = ($countones(c6) > 3) ? 1'b1 : (($countones(c6) < 3) ? 1'b0 : rd_i);
      if ((b[7:5] == 3'd7) &&
          ((!r4 && (b[4:0] == 5'd17 || b[4:0] == 5'd18 || b[4:0] == 5'd20)) ||
           ( r4 && (b[4:0] == 5'd11 || b[4:0] == 5'd13 || b[4:0] == 5'd14))))
        c4 = 4'b0111;
      else
        c4 = D4[b[7:5]];
      if (r4 && (($countones(c4) != 2) || (c4 == 4'b1100))) c4 = ~c4;
      c = {c6, c4};
    end
    ones = $countones(c);
    for (int j = 0; j < 10; j++) o[j] = c[9-j];
    model_enc = {(ones > 5) ? 1'b1 : ((ones < 5) ? 1'b0 : rd_i), o};
  endfunction

  // One clock: check handshake, retire consumed beat, predict next load, advance.
  task automatic step();
    logic             free;
    logic [LANES-1:0] rd_n;
    logic [LANES*10-1:0] d;
    logic [10:0]      r;
    logic [7:0]       b;
    logic             k;
    int               nbad;
    int               sum;
    exp_t             e;
    #1;
    free = !mdl_valid || m_ready;
    nvec++;
    if (s_ready !== free) begin
      nmis++;
      $display("FAIL s_ready: got %b want %b", s_ready, free);
    end
    if (mdl_valid && m_ready && sb.size() > 0) begin
      e = sb.pop_front();
      nvec++;
      if (m_data !== e.data || m_idle !== e.idle || m_disp !== e.disp) begin
        nmis++;
        $display("FAIL sb_beat: got data=%h idle=%b disp=%b want data=%h idle=%b disp=%b",
                 m_data, m_idle, m_disp, e.data, e.idle, e.disp);
      end
    end
    mdl_kerr = 1'b0;
    if (rst) begin
      mdl_valid = 1'b0;
      mdl_rd    = '0;
      mdl_cnt   = '0;
      sb.delete();
    end else begin
      rd_n = disp_clr ? '0 : mdl_rd;
      if (free && (s_valid || IDLE_INSERT)) begin
        nbad = 0;
        d    = '0;
        for (int i = 0; i < LANES; i++) begin
          if (lane_en[i]) begin
            b = s_valid ? s_data[8*i +: 8] : 8'hBC;
            k = s_valid ? s_ctrl[i] : 1'b1;
            if (k && !is_k(b)) nbad++;
            r = model_enc(b, k && is_k(b), rd_n[i]);
            d[10*i +: 10] = r[9:0];
            rd_n[i] = r[10];
          end
        end
        e.data = d;
        e.idle = !s_valid;
        e.disp = rd_n;
        sb.push_back(e);
        mdl_valid = 1'b1;
        if (nbad > 0) begin
          mdl_kerr = 1'b1;
          sum = int'(mdl_cnt) + nbad;
          mdl_cnt = (sum > 15) ? 4'hF : 4'(sum);
        end
      end else if (free) begin
        mdl_valid = 1'b0;
      end
      mdl_rd = rd_n;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (m_valid !== mdl_valid || k_err !== mdl_kerr || k_err_cnt !== mdl_cnt) begin
      nmis++;
      $display("FAIL status: got valid=%b kerr=%b cnt=%0d want valid=%b kerr=%b cnt=%0d",
               m_valid, k_err, k_err_cnt, mdl_valid, mdl_kerr, mdl_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_ctrl = '0; s_data = '0; lane_en = 4'hF;
    disp_clr = 1'b0; m_ready = 1'b1;
    mdl_valid = 1'b0; mdl_rd = '0; mdl_cnt = '0; mdl_kerr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nvec++;
    if (m_valid !== 1'b0 || m_idle !== 1'b0 || m_data !== '0 || m_disp !== '0 ||
        k_err !== 1'b0 || k_err_cnt !== '0 || s_ready !== 1'b1) begin
      nmis++;
      $display("FAIL reset_state: got v=%b i=%b d=%h disp=%b ke=%b cnt=%0d rdy=%b want all zero, rdy=1",
               m_valid, m_idle, m_data, m_disp, k_err, k_err_cnt, s_ready);
    end
  endtask

  task automatic test_idle();
    rst = 1'b0; s_valid = 1'b0;
    step();
    nvec++;
    if (m_data[9:0] !== 10'h17C || m_disp[0] !== 1'b1 || m_idle !== 1'b1 || m_valid !== 1'b1) begin
      nmis++;
      $display("FAIL idle_first: got %h disp=%b idle=%b want 17c disp=1 idle=1", m_data[9:0], m_disp[0], m_idle);
    end
    step();
    nvec++;
    if (m_data[9:0] !== 10'h283 || m_disp[0] !== 1'b0 || m_idle !== 1'b1) begin
      nmis++;
      $display("FAIL idle_second: got %h disp=%b idle=%b want 283 disp=0 idle=1", m_data[9:0], m_disp[0], m_idle);
    end
  endtask

  task automatic test_data();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_ctrl = 4'h0; s_data = {4{8'hB5}};
    step();
    s_valid = 1'b0;
    nvec++;
    if (m_data[9:0] !== 10'h155 || m_disp[0] !== 1'b0 || m_idle !== 1'b0) begin
      nmis++;
      $display("FAIL data_d21_5: got %h disp=%b idle=%b want 155 disp=0 idle=0", m_data[9:0], m_disp[0], m_idle);
    end
  endtask

  task automatic test_kerr();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_ctrl = 4'b0001; s_data = 32'h0;
    step();
    s_valid = 1'b0; s_ctrl = 4'h0;
    nvec++;
    if (m_data[9:0] !== 10'h0B9 || k_err !== 1'b1 || k_err_cnt !== 4'd1 || m_disp[0] !== 1'b0) begin
      nmis++;
      $display("FAIL bad_k: got %h ke=%b cnt=%0d disp=%b want 0b9 ke=1 cnt=1 disp=0",
               m_data[9:0], k_err, k_err_cnt, m_disp[0]);
    end
    step();
    nvec++;
    if (k_err !== 1'b0 || k_err_cnt !== 4'd1) begin
      nmis++;
      $display("FAIL bad_k_pulse: got ke=%b cnt=%0d want ke=0 cnt=1", k_err, k_err_cnt);
    end
  endtask

  task automatic test_disp_clr();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_ctrl = 4'b0001; s_data = {4{8'hBC}};
    step();
    nvec++;
    if (m_data[9:0] !== 10'h17C || m_disp[0] !== 1'b1) begin
      nmis++;
      $display("FAIL clr_setup: got %h disp=%b want 17c disp=1", m_data[9:0], m_disp[0]);
    end
    disp_clr = 1'b1;
    step();
    disp_clr = 1'b0; s_valid = 1'b0; s_ctrl = 4'h0;
    nvec++;
    if (m_data[9:0] !== 10'h17C || m_disp[0] !== 1'b1) begin
      nmis++;
      $display("FAIL disp_clr_load: got %h disp=%b want 17c disp=1", m_data[9:0], m_disp[0]);
    end
  endtask

  task automatic test_lane_en();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_ctrl = 4'hF; s_data = {4{8'hBC}};
    step();
    lane_en = 4'b1101; s_ctrl = 4'h0; s_data = {4{8'hB5}};
    step();
    lane_en = 4'hF; s_valid = 1'b0;
    nvec++;
    if (m_data !== {10'h155, 10'h155, 10'h000, 10'h155} || m_disp !== 4'hF) begin
      nmis++;
      $display("FAIL lane_disable: got %h disp=%b want 155_155_000_155 disp=1111", m_data, m_disp);
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b0;
    step();
    m_ready = 1'b0; s_valid = 1'b1; s_ctrl = 4'h0; s_data = {4{8'hB5}};
    for (int n = 0; n < 3; n++) begin
      step();
      nvec++;
      if (s_ready !== 1'b0 || m_data !== {4{10'h17C}} || m_disp !== 4'hF || m_idle !== 1'b1) begin
        nmis++;
        $display("FAIL stall_hold: got rdy=%b %h disp=%b idle=%b want rdy=0 17c x4 disp=1111 idle=1",
                 s_ready, m_data, m_disp, m_idle);
      end
    end
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    nvec++;
    if (m_valid !== 1'b1 || m_idle !== 1'b0 || m_data[9:0] !== 10'h155) begin
      nmis++;
      $display("FAIL stall_release: got v=%b idle=%b %h want v=1 idle=0 155", m_valid, m_idle, m_data[9:0]);
    end
  endtask

  task automatic test_midreset();
    m_ready = 1'b0; s_valid = 1'b1; s_data = {4{8'h4A}};
    step();
    rst = 1'b1;
    step();
    nvec++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== '0) begin
      nmis++;
      $display("FAIL mid_reset: got v=%b rdy=%b %h want v=0 rdy=1 0", m_valid, s_ready, m_data);
    end
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
  endtask

  task automatic test_saturate();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_ctrl = 4'hF; s_data = 32'h0;
    for (int n = 0; n < 5; n++) step();
    nvec++;
    if (k_err_cnt !== 4'hF || k_err !== 1'b1) begin
      nmis++;
      $display("FAIL cnt_saturate: got cnt=%0d ke=%b want 15 ke=1", k_err_cnt, k_err);
    end
    s_valid = 1'b0; s_ctrl = 4'h0;
    step();
    nvec++;
    if (k_err_cnt !== 4'hF || k_err !== 1'b0) begin
      nmis++;
      $display("FAIL cnt_hold: got cnt=%0d ke=%b want 15 ke=0", k_err_cnt, k_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] kb [5];
    kb[0] = 8'hBC; kb[1] = 8'hF7; kb[2] = 8'hFB; kb[3] = 8'hFD; kb[4] = 8'hFE;
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      lane_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      disp_clr = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < LANES; i++) begin
        s_ctrl[i] = ($urandom_range(0, 5) == 0);
        if (s_ctrl[i] && $urandom_range(0, 3) != 0) begin
          s_data[8*i +: 8] = kb[$urandom_range(0, 4)] | ((kb[0] == 8'hBC) ? {3'($urandom), 5'd0} & 8'h00 : 8'h00);
          if ($urandom_range(0, 1) == 1) s_data[8*i +: 8] = {3'($urandom), 5'd28};
        end else begin
          s_data[8*i +: 8] = 8'($urandom);
        end
      end
      step();
    end
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1; disp_clr = 1'b0; lane_en = 4'hF;
    step();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_data();
    test_kerr();
    test_disp_clr();
    test_lane_en();
    test_stall();
    test_midreset();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
